// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/I-O responder: latches an access, counts wait states, pulses R and returns read data.
// Define LC3_MEM_IO_EN to include the keyboard/display registers at xFE00-xFE06.
//
// state | meaning
// IDLE  | no access in flight; MIO_EN high latches MAR/R_W/MDR_in
// WAIT  | counting wait states; MIO_EN low abandons the access
// READY | R high; write commits and read completes at the closing edge
module lc3_mem_ctrl #(
    parameter int MEM_WORDS   = 4096,
    parameter int WAIT_STATES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR_in,
    output logic [15:0] MDR_out,
    output logic        R,
    output logic        INT,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        start, enter_ready;
    logic [15:0] addr_q, wdata_q;
    logic        rw_q;
    logic [15:0] acc_addr;
    logic        acc_rw;
    logic        io_hit, ram_hit;
    logic [15:0] io_data, rd_data;
    logic [15:0] mem [MEM_WORDS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        start       = 1'b0;
        enter_ready = 1'b0;
        case (state)
            IDLE: begin
                if (MIO_EN) begin
                    start = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt   = READY;
                        enter_ready = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = WS_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!MIO_EN) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt   = READY;
                    enter_ready = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            READY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
        end else if (start) begin
            addr_q  <= MAR;
            wdata_q <= MDR_in;
            rw_q    <= R_W;
        end
    end

    // With zero wait states READY is entered straight from IDLE, before the latch holds the access.
    assign acc_addr = (state == IDLE) ? MAR : addr_q;
    assign acc_rw   = (state == IDLE) ? R_W : rw_q;
    assign ram_hit  = !io_hit && ({16'h0000, acc_addr} < 32'(MEM_WORDS));
    assign rd_data  = io_hit ? io_data : (ram_hit ? mem[acc_addr[AW-1:0]] : 16'h0000);

    always_ff @(posedge clk) begin
        if (state == READY && rw_q && ram_hit)
            mem[addr_q[AW-1:0]] <= wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            R       <= 1'b0;
            MDR_out <= '0;
        end else begin
            R <= enter_ready;
            if (enter_ready && !acc_rw)
                MDR_out <= rd_data;
        end
    end

`ifdef LC3_MEM_IO_EN
    localparam logic [15:0] KBSR_A = 16'hFE00;
    localparam logic [15:0] KBDR_A = 16'hFE02;
    localparam logic [15:0] DSR_A  = 16'hFE04;
    localparam logic [15:0] DDR_A  = 16'hFE06;

    logic       kbsr_rdy, kbsr_ie;
    logic [7:0] kbdr;
    logic       io_wr, kbdr_rd;

    always_comb begin
        io_hit  = 1'b1;
        io_data = 16'h0000;
        case (acc_addr)
            KBSR_A:  io_data = {kbsr_rdy, kbsr_ie, 14'h0000};
            KBDR_A:  io_data = {8'h00, kbdr};
            DSR_A:   io_data = {~disp_valid, 15'h0000};
            DDR_A:   io_data = 16'h0000;
            default: io_hit  = 1'b0;
        endcase
    end

    assign io_wr   = (state == READY) && rw_q;
    assign kbdr_rd = (state == READY) && !rw_q && (addr_q == KBDR_A);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kbsr_rdy   <= 1'b0;
            kbsr_ie    <= 1'b0;
            kbdr       <= '0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            INT        <= 1'b0;
        end else begin
            if (io_wr && addr_q == KBSR_A)
                kbsr_ie <= wdata_q[14];
            // A strobe that lands on the KBDR read completion refills the register rather than overrunning.
            if (kb_valid && (kbdr_rd || !kbsr_rdy)) begin
                kbdr     <= kb_data;
                kbsr_rdy <= 1'b1;
            end else if (kbdr_rd) begin
                kbsr_rdy <= 1'b0;
            end
            if (io_wr && addr_q == DDR_A && !disp_valid) begin
                disp_data  <= wdata_q[7:0];
                disp_valid <= 1'b1;
            end else if (disp_valid && disp_ready) begin
                disp_valid <= 1'b0;
            end
            INT <= kbsr_rdy & kbsr_ie;
        end
    end
`else
    logic unused_io;

    assign io_hit     = 1'b0;
    assign io_data    = 16'h0000;
    assign INT        = 1'b0;
    assign disp_valid = 1'b0;
    assign disp_data  = 8'h00;
    assign unused_io  = ^{kb_valid, kb_data, disp_ready};
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: access-level model checked every cycle plus directed literals.
// Covers both LC3_MEM_IO_EN builds; a second instance exercises zero wait states.
module tb_lc3_mem_ctrl;
    localparam int MW = 4096;
    localparam int WS = 3;
`ifdef LC3_MEM_IO_EN
    localparam bit IO = 1'b1;
`else
    localparam bit IO = 1'b0;
`endif

    logic        clk, reset;
    logic        mio, r_w;
    logic [15:0] mar, mdr_in, mdr_out;
    logic        r, intr, kb_valid, dv, disp_ready;
    logic [7:0]  kb_data, dd;

    logic        mio0, rw0, r0, int0, dv0;
    logic [15:0] mar0, mdri0, mdro0;
    logic [7:0]  dd0;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    lc3_mem_ctrl #(.MEM_WORDS(MW), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .reset(reset), .MIO_EN(mio), .R_W(r_w), .MAR(mar), .MDR_in(mdr_in),
        .MDR_out(mdr_out), .R(r), .INT(intr), .kb_valid(kb_valid), .kb_data(kb_data),
        .disp_valid(dv), .disp_data(dd), .disp_ready(disp_ready)
    );

    lc3_mem_ctrl #(.MEM_WORDS(MW), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .MIO_EN(mio0), .R_W(rw0), .MAR(mar0), .MDR_in(mdri0),
        .MDR_out(mdro0), .R(r0), .INT(int0), .kb_valid(1'b0), .kb_data(8'h00),
        .disp_valid(dv0), .disp_data(dd0), .disp_ready(1'b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Access-level model: an access starts on an edge seeing MIO_EN in idle, becomes ready WS edges later
    // unless MIO_EN drops first, and takes effect on the edge that closes the ready cycle.
    logic [15:0] ram_m [MW];
    bit          act, a_rw;
    logic [15:0] a_addr, a_wd;
    int          rem;
    bit          m_rdy, m_ie, m_dv, m_int, exp_r;
    logic [7:0]  m_kbdr, m_dd;
    logic [15:0] exp_mdr;

    function automatic logic [15:0] rd_val(input logic [15:0] a);
        if (IO && a == 16'hFE00) return {m_rdy, m_ie, 14'h0000};
        if (IO && a == 16'hFE02) return {8'h00, m_kbdr};
        if (IO && a == 16'hFE04) return {~m_dv, 15'h0000};
        if (IO && a == 16'hFE06) return 16'h0000;
        if (int'(a) < MW) return ram_m[a[11:0]];
        return 16'h0000;
    endfunction

    always @(posedge clk or posedge reset) begin
        bit ready_now, kb_rd, o_rdy, o_ie, o_dv, new_r;
        if (reset) begin
            act = 0; m_rdy = 0; m_ie = 0; m_kbdr = 8'h00; m_dv = 0; m_dd = 8'h00;
            m_int = 0; exp_r = 0; exp_mdr = 16'h0000;
        end else begin
            ready_now = exp_r;
            o_rdy = m_rdy; o_ie = m_ie; o_dv = m_dv;
            kb_rd = 0; new_r = 0;
            if (!ready_now) begin
                if (!act) begin
                    if (mio) begin
                        act = 1; a_rw = r_w; a_addr = mar; a_wd = mdr_in; rem = WS;
                    end
                end else if (!mio) begin
                    act = 0;
                end else begin
                    rem--;
                end
                if (act && rem == 0) begin
                    new_r = 1;
                    if (!a_rw) exp_mdr = rd_val(a_addr);
                end
            end else begin
                act = 0;
                if (a_rw) begin
                    if (IO && a_addr == 16'hFE00) m_ie = a_wd[14];
                    else if (IO && a_addr == 16'hFE06) begin
                        if (!o_dv) begin m_dd = a_wd[7:0]; m_dv = 1; end
                    end
                    else if (IO && (a_addr == 16'hFE02 || a_addr == 16'hFE04)) ;
                    else if (int'(a_addr) < MW) ram_m[a_addr[11:0]] = a_wd;
                end else if (IO && a_addr == 16'hFE02) begin
                    kb_rd = 1;
                end
            end
            if (o_dv && disp_ready) m_dv = 0;
            if (IO) begin
                if (kb_rd && kb_valid) begin m_kbdr = kb_data; m_rdy = 1; end
                else if (kb_rd) m_rdy = 0;
                else if (kb_valid && !o_rdy) begin m_kbdr = kb_data; m_rdy = 1; end
            end
            m_int = IO && o_rdy && o_ie;
            exp_r = new_r;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("R", 16'(r), 16'(exp_r));
            check("MDR_out", mdr_out, exp_mdr);
            check("INT", 16'(intr), 16'(m_int));
            check("disp_valid", 16'(dv), 16'(m_dv));
            check("disp_data", 16'(dd), 16'(m_dd));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit rw, input logic [15:0] addr, input logic [15:0] wd,
                          input bit kb_at_rdy, input logic [7:0] kbc, output int lat);
        mio = 1; r_w = rw; mar = addr; mdr_in = wd;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (r !== 1'b1 && lat < 40);
        if (r !== 1'b1) check("R timeout", 16'(r), 16'h0001);
        mio = 0; r_w = 0;
        if (kb_at_rdy) begin kb_valid = 1; kb_data = kbc; end
        tick();
        kb_valid = 0;
    endtask

    task automatic kb_pulse(input logic [7:0] c);
        kb_valid = 1; kb_data = c;
        tick();
        kb_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, rcnt;
        mio = 0; r_w = 0; mar = 0; mdr_in = 0; kb_valid = 0; kb_data = 0; disp_ready = 0;
        mio0 = 0; rw0 = 0; mar0 = 0; mdri0 = 0;
        reset = 0;
        #2 reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk_en = 1;
        check("rst R", 16'(r), 16'h0000);
        check("rst MDR_out", mdr_out, 16'h0000);
        check("rst INT", 16'(intr), 16'h0000);
        check("rst disp_valid", 16'(dv), 16'h0000);

        // zero wait states: writes, then back-to-back reads with MIO_EN held high
        mio0 = 1; rw0 = 1; mar0 = 16'h0000; mdri0 = 16'hAAAA; tick();
        check("ws0 wr R", 16'(r0), 16'h0001);
        mio0 = 0; rw0 = 0; tick();
        mio0 = 1; rw0 = 1; mar0 = 16'h0001; mdri0 = 16'h5555; tick();
        mio0 = 0; rw0 = 0; tick();
        mio0 = 1; mar0 = 16'h0000; tick();
        check("ws0 rd0 R", 16'(r0), 16'h0001);
        check("ws0 rd0 data", mdro0, 16'hAAAA);
        tick();
        check("ws0 gap R", 16'(r0), 16'h0000);
        mar0 = 16'h0001; tick();
        check("ws0 rd1 R", 16'(r0), 16'h0001);
        check("ws0 rd1 data", mdro0, 16'h5555);
        tick();
        check("ws0 end R", 16'(r0), 16'h0000);
        mio0 = 0;
        check("ws0 INT", 16'(int0), 16'h0000);
        check("ws0 disp", {7'h00, dv0, dd0}, 16'h0000);

        // write then read with three wait states
        access(1, 16'h0010, 16'h1234, 0, 8'h00, lat);
        check("wr latency", 16'(lat), 16'd4);
        access(0, 16'h0010, 16'h0000, 0, 8'h00, lat);
        check("rd latency", 16'(lat), 16'd4);
        check("rd data", mdr_out, 16'h1234);

        // abort in WAIT
        access(1, 16'h0020, 16'h1111, 0, 8'h00, lat);
        mio = 1; r_w = 1; mar = 16'h0020; mdr_in = 16'hBEEF;
        tick(); tick();
        mio = 0; r_w = 0;
        rcnt = 0;
        repeat (6) begin tick(); if (r === 1'b1) rcnt++; end
        check("abort R count", 16'(rcnt), 16'h0000);
        access(0, 16'h0020, 16'h0000, 0, 8'h00, lat);
        check("abort old data", mdr_out, 16'h1111);

        // out-of-range and write-holds-MDR
        access(1, 16'h3000, 16'hDEAD, 0, 8'h00, lat);
        access(0, 16'h3000, 16'h0000, 0, 8'h00, lat);
        check("oor read", mdr_out, 16'h0000);
        access(1, 16'h0030, 16'h5A5A, 0, 8'h00, lat);
        check("write keeps MDR", mdr_out, 16'h0000);

        // keyboard
        kb_pulse(8'h41);
        kb_pulse(8'h42);
        access(1, 16'hFE00, 16'h4000, 0, 8'h00, lat);
        tick(); tick();
        check("INT set", 16'(intr), IO ? 16'h0001 : 16'h0000);
        access(0, 16'hFE02, 16'h0000, 0, 8'h00, lat);
        check("KBDR read", mdr_out, IO ? 16'h0041 : 16'h0000);
        tick(); tick();
        check("INT clear", 16'(intr), 16'h0000);
        access(0, 16'hFE00, 16'h0000, 0, 8'h00, lat);
        check("KBSR after read", mdr_out, IO ? 16'h4000 : 16'h0000);
        kb_pulse(8'h43);
        access(0, 16'hFE02, 16'h0000, 1, 8'h44, lat);
        check("KBDR old char", mdr_out, IO ? 16'h0043 : 16'h0000);
        access(0, 16'hFE00, 16'h0000, 0, 8'h00, lat);
        check("KBSR refilled", mdr_out, IO ? 16'hC000 : 16'h0000);
        access(0, 16'hFE02, 16'h0000, 0, 8'h00, lat);
        check("KBDR new char", mdr_out, IO ? 16'h0044 : 16'h0000);

        // display
        access(1, 16'hFE06, 16'h0058, 0, 8'h00, lat);
        check("DDR valid", 16'(dv), IO ? 16'h0001 : 16'h0000);
        check("DDR data", 16'(dd), IO ? 16'h0058 : 16'h0000);
        access(0, 16'hFE04, 16'h0000, 0, 8'h00, lat);
        check("DSR busy", mdr_out, 16'h0000);
        access(1, 16'hFE06, 16'h0059, 0, 8'h00, lat);
        check("DDR ignored", 16'(dd), IO ? 16'h0058 : 16'h0000);
        disp_ready = 1;
        tick(); tick();
        check("disp cleared", 16'(dv), 16'h0000);
        disp_ready = 0;
        access(0, 16'hFE04, 16'h0000, 0, 8'h00, lat);
        check("DSR idle", mdr_out, IO ? 16'h8000 : 16'h0000);

        // reset in the middle of a write
        mio = 1; r_w = 1; mar = 16'h0010; mdr_in = 16'h7777;
        tick(); tick();
        reset = 1;
        #1;
        check("mid rst R", 16'(r), 16'h0000);
        check("mid rst MDR_out", mdr_out, 16'h0000);
        check("mid rst INT", 16'(intr), 16'h0000);
        check("mid rst disp", {7'h00, dv, dd}, 16'h0000);
        mio = 0; r_w = 0;
        tick();
        reset = 0;
        tick();
        access(0, 16'h0010, 16'h0000, 0, 8'h00, lat);
        check("rst no write", mdr_out, 16'h1234);

        tick();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
